// File: rtl/aes_key_sched_serial.sv
// Serial AES key expansion. Produces one 32-bit schedule word per cycle and
// hands out 128-bit round keys over a valid/ready interface. Supports
// 128/192/256-bit keys up to the MAX_NK limit.
module aes_key_sched_serial #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  localparam logic [3:0] MaxNkW = 4'(MAX_NK);

  // Forward S-box, element 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    nk_q, nk_d;
  logic [5:0]    lastIdx_q, lastIdx_d;
  // Index of the next word to produce. The accept edge itself emits w[0]
  // (it is simply key word 0), so the counter leaves IDLE already at 1.
  logic [5:0]    wordIdx_q, wordIdx_d;
  logic [2:0]    modCnt_q, modCnt_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [31:0]   hist_q [MAX_NK];
  logic [31:0]   hist_d [MAX_NK];
  logic [31:0]   asm_q [3];
  logic [31:0]   asm_d [3];
  logic [127:0]  rkOut_q, rkOut_d;
  logic [3:0]    rkIndex_q, rkIndex_d;
  logic          rkValid_q, rkValid_d;
  logic          err_q, err_d;

  logic [3:0]    reqNk;
  logic [5:0]    reqLastIdx;
  logic          startLegal;
  logic          transfer;
  logic          produce;
  logic [3:0]    nkMinus1;
  logic [31:0]   prevWord;
  logic [31:0]   keyWord;
  logic [31:0]   tempWord;
  logic [31:0]   genWord;
  logic          unusedKeyBits;

  assign unusedKeyBits = ^key_in;

  // Decode the requested key length and judge whether a start is acceptable.
  always_comb begin
    reqNk      = 4'd0;
    reqLastIdx = 6'd0;
    case (key_size)
      2'b00:   begin reqNk = 4'd4; reqLastIdx = 6'd43; end
      2'b01:   begin reqNk = 4'd6; reqLastIdx = 6'd51; end
      2'b10:   begin reqNk = 4'd8; reqLastIdx = 6'd59; end
      default: begin reqNk = 4'd0; reqLastIdx = 6'd0;  end
    endcase
    startLegal = (key_size != 2'b11) && (reqNk <= MaxNkW);
  end

  // Compute the next schedule word from the history window.
  always_comb begin
    nkMinus1 = nk_q - 4'd1;
    prevWord = hist_q[0];
    keyWord  = hist_q[0];
    for (int j = 0; j < MAX_NK; j++) begin
      if (4'(j) == nkMinus1) prevWord = hist_q[j];
      if (6'(j) == wordIdx_q) keyWord = hist_q[j];
    end
    tempWord = prevWord;
    if (modCnt_q == 3'd0)
      tempWord = subWord({prevWord[23:0], prevWord[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && modCnt_q == 3'd4)
      tempWord = subWord(prevWord);
    genWord = (wordIdx_q < {2'b00, nk_q}) ? keyWord : (hist_q[0] ^ tempWord);
  end

  assign transfer = rkValid_q && rk_ready;
  assign produce  = (state_q == GEN) &&
                    ((wordIdx_q[1:0] != 2'd3) || !rkValid_q || rk_ready);

  // Next-state logic for the FSM, generator datapath and round-key register.
  always_comb begin
    state_d   = state_q;
    nk_d      = nk_q;
    lastIdx_d = lastIdx_q;
    wordIdx_d = wordIdx_q;
    modCnt_d  = modCnt_q;
    rcon_d    = rcon_q;
    hist_d    = hist_q;
    asm_d     = asm_q;
    rkOut_d   = rkOut_q;
    rkIndex_d = rkIndex_q;
    rkValid_d = rkValid_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (startLegal) begin
            for (int j = 0; j < MAX_NK; j++)
              hist_d[j] = key_in[255-32*j -: 32];
            asm_d[0]  = key_in[255:224];
            nk_d      = reqNk;
            lastIdx_d = reqLastIdx;
            wordIdx_d = 6'd1;
            modCnt_d  = 3'd1;
            rcon_d    = 8'h01;
            state_d   = GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GEN: begin
        if (transfer) rkValid_d = 1'b0;
        if (produce) begin
          if (wordIdx_q[1:0] == 2'd3) begin
            rkOut_d   = {asm_q[0], asm_q[1], asm_q[2], genWord};
            rkIndex_d = wordIdx_q[5:2];
            rkValid_d = 1'b1;
          end else begin
            for (int j = 0; j < 3; j++)
              if (2'(j) == wordIdx_q[1:0]) asm_d[j] = genWord;
          end
          if (wordIdx_q >= {2'b00, nk_q}) begin
            for (int j = 0; j < MAX_NK - 1; j++)
              if (4'(j) < nkMinus1) hist_d[j] = hist_q[j+1];
            for (int j = 0; j < MAX_NK; j++)
              if (4'(j) == nkMinus1) hist_d[j] = genWord;
            if (modCnt_q == 3'd0) rcon_d = xtime(rcon_q);
          end
          modCnt_d  = ({1'b0, modCnt_q} == nkMinus1) ? 3'd0 : modCnt_q + 3'd1;
          wordIdx_d = wordIdx_q + 6'd1;
          if (wordIdx_q == lastIdx_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (transfer) begin
          rkValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nk_q      <= 4'd0;
      lastIdx_q <= 6'd0;
      wordIdx_q <= 6'd0;
      modCnt_q  <= 3'd0;
      rcon_q    <= 8'h01;
      for (int j = 0; j < MAX_NK; j++) hist_q[j] <= 32'h0;
      for (int j = 0; j < 3; j++) asm_q[j] <= 32'h0;
      rkOut_q   <= 128'h0;
      rkIndex_q <= 4'd0;
      rkValid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nk_q      <= nk_d;
      lastIdx_q <= lastIdx_d;
      wordIdx_q <= wordIdx_d;
      modCnt_q  <= modCnt_d;
      rcon_q    <= rcon_d;
      hist_q    <= hist_d;
      asm_q     <= asm_d;
      rkOut_q   <= rkOut_d;
      rkIndex_q <= rkIndex_d;
      rkValid_q <= rkValid_d;
      err_q     <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = rkValid_q;
  assign rk_out   = rkOut_q;
  assign rk_index = rkIndex_q;
  assign rk_last  = rkValid_q && (rkIndex_q == (nk_q + 4'd6));
  assign err      = err_q;

endmodule

// File: tb/tb_aes_key_sched_serial.sv
// Testbench for aes_key_sched_serial: table-driven expansions checked against
// an independent behavioural key-schedule model, plus rejection sequences.
module tb_aes_key_sched_serial;

  typedef struct {
    logic [1:0]   ks;
    logic [255:0] key;
    logic [127:0] finalKey;
    int           nTransfers;
    bit           stall;
    int           rstRound;
    bit           busyStart;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start4;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         rk_ready;
  logic         busy, rk_valid, rk_last, err;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         busy4, rkValid4, rkLast4, err4;
  logic [127:0] rkOut4;
  logic [3:0]   rkIndex4;

  int vecCount  = 0;
  int missCount = 0;

  logic [7:0]  sboxTab [0:255];
  logic [31:0] modelW [0:59];
  int          modelNr;
  vec_t        vecs [6];

  aes_key_sched_serial #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_index(rk_index), .rk_last(rk_last), .err(err)
  );

  aes_key_sched_serial #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_size(key_size), .key_in(key_in),
    .busy(busy4), .rk_valid(rkValid4), .rk_ready(rk_ready), .rk_out(rkOut4),
    .rk_index(rkIndex4), .rk_last(rkLast4), .err(err4)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                   rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] modelSub(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  task automatic buildModel(input logic [1:0] ks, input logic [255:0] key);
    int nk;
    logic [7:0]  rcon;
    logic [31:0] t;
    nk = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
    modelNr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (modelNr + 1); i++) begin
      if (i < nk) begin
        modelW[i] = key[255-32*i -: 32];
      end else begin
        t = modelW[i-1];
        if (i % nk == 0) begin
          t = modelSub({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end else if (nk == 8 && i % 8 == 4) begin
          t = modelSub(t);
        end
        modelW[i] = modelW[i-nk] ^ t;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one table vector from start through the final transfer.
  task automatic applyStimulus(input int v);
    int edgeN, transfers, lastEdge, stallLeft;
    bit heldValid, aborted, timedOut;
    logic [127:0] heldOut, firstOut, finalOut;
    logic [3:0]   heldIdx;
    int r;
    buildModel(vecs[v].ks, vecs[v].key);
    transfers = 0; lastEdge = -1; stallLeft = 0;
    heldValid = 0; aborted = 0; timedOut = 0;
    heldOut = '0; heldIdx = '0; firstOut = '0; finalOut = '0;
    @(negedge clk);
    key_size = vecs[v].ks;
    key_in   = vecs[v].key;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk);
    edgeN = 0;
    forever begin
      @(negedge clk);
      if (edgeN == 0) begin
        start = 1'b0;
        checkOutput("busy_after_accept", 128'(busy), 128'(1));
      end else if (!busy) begin
        break;
      end
      if (vecs[v].rstRound >= 0 && rk_valid && int'(rk_index) == vecs[v].rstRound) begin
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_rk_valid", 128'(rk_valid), 128'(0));
        checkOutput("rst_rk_out", rk_out, 128'h0);
        checkOutput("rst_rk_index", 128'(rk_index), 128'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_start_ignored", 128'(busy), 128'(0));
        aborted = 1;
        break;
      end
      if (vecs[v].busyStart && edgeN == 9) begin
        key_size = 2'b00;
        key_in   = ~vecs[v].key;
        start    = 1'b1;
      end else if (vecs[v].busyStart && edgeN == 10) begin
        start    = 1'b0;
        key_size = vecs[v].ks;
        key_in   = vecs[v].key;
      end
      if (heldValid) begin
        checkOutput("stall_rk_out_stable", rk_out, heldOut);
        checkOutput("stall_rk_index_stable", 128'(rk_index), 128'(heldIdx));
        heldValid = 0;
      end
      if (vecs[v].stall) begin
        rk_ready = (stallLeft == 0);
        if (stallLeft > 0) stallLeft--;
      end else begin
        rk_ready = 1'b1;
      end
      if (rk_valid && rk_ready) begin
        r = transfers;
        if (r <= modelNr) begin
          checkOutput($sformatf("rk_out_%0d_%0d", v, r), rk_out,
                      {modelW[4*r], modelW[4*r+1], modelW[4*r+2], modelW[4*r+3]});
        end
        checkOutput("rk_index", 128'(rk_index), 128'(r));
        checkOutput("rk_last", 128'(rk_last), 128'(r == modelNr));
        if (!vecs[v].stall)
          checkOutput("transfer_edge", 128'(edgeN + 1), 128'(4 * (r + 1)));
        if (r == 0) firstOut = rk_out;
        finalOut = rk_out;
        transfers++;
        lastEdge = edgeN + 1;
        if (vecs[v].stall) stallLeft = $urandom_range(0, 7);
      end else if (rk_valid) begin
        heldValid = 1;
        heldOut = rk_out;
        heldIdx = rk_index;
      end
      @(posedge clk);
      edgeN++;
      if (edgeN > 1500) begin
        timedOut = 1;
        break;
      end
    end
    if (timedOut) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL timeout_vec%0d: busy still %0d after %0d edges, required 0", v, busy, edgeN);
    end else if (!aborted) begin
      checkOutput("transfer_count", 128'(transfers), 128'(vecs[v].nTransfers));
      checkOutput("first_key", firstOut, vecs[v].key[255:128]);
      checkOutput("final_key", finalOut, vecs[v].finalKey);
      checkOutput("busy_fall_edge", 128'(edgeN), 128'(lastEdge));
      if (!vecs[v].stall)
        checkOutput("final_transfer_edge", 128'(lastEdge), 128'(4 * vecs[v].nTransfers));
    end
    rk_ready = 1'b1;
  endtask

  // Main test sequence.
  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; key_size = 2'b00;
    key_in = '0; rk_ready = 1'b1;

    vecs[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdefcafef00d},
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11, 1'b0, -1, 1'b0};
    vecs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                128'he98ba06f448c773c8ecc720401002202, 13, 1'b0, -1, 1'b1};
    vecs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'hfe4890d1e6188d0b046df344706c631e, 15, 1'b0, -1, 1'b0};
    vecs[3] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'hfe4890d1e6188d0b046df344706c631e, 15, 1'b1, -1, 1'b0};
    vecs[4] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11, 1'b0, 5, 1'b0};
    vecs[5] = vecs[0];

    buildSbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_rk_valid", 128'(rk_valid), 128'(0));
    checkOutput("reset_rk_out", rk_out, 128'h0);
    checkOutput("reset_rk_index", 128'(rk_index), 128'(0));
    checkOutput("reset_rk_last", 128'(rk_last), 128'(0));
    checkOutput("reset_err", 128'(err), 128'(0));
    rst = 1'b0;

    // Reserved key size is rejected with a single-cycle err pulse.
    @(negedge clk);
    key_size = 2'b11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("reserved_err", 128'(err), 128'(1));
    checkOutput("reserved_busy", 128'(busy), 128'(0));
    checkOutput("reserved_rk_valid", 128'(rk_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("reserved_err_pulse", 128'(err), 128'(0));

    // A 256-bit key exceeds a MAX_NK=4 instance.
    key_size = 2'b10; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("maxnk_err", 128'(err4), 128'(1));
    checkOutput("maxnk_busy", 128'(busy4), 128'(0));
    checkOutput("maxnk_main_err", 128'(err), 128'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("maxnk_err_pulse", 128'(err4), 128'(0));

    for (int v = 0; v < 6; v++) begin
      $display("[TB] vector %0d key_size=%0d stall=%0d", v, vecs[v].ks, vecs[v].stall);
      applyStimulus(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_serial.md
AES_KEY_SCHED_SERIAL -- requirements
Module: aes_key_sched_serial

Interface
REQ-001 The block SHALL have parameter MAX_NK, default 8, meaning the largest key length supported in 32-bit words; legal values are 4, 6 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to expand key_in; sampled only in IDLE.
REQ-005 The block SHALL have port key_size, input, 2 bits: 00 = 128-bit key (Nk=4, 11 round keys); 01 = 192-bit (Nk=6, 13); 10 = 256-bit (Nk=8, 15); 11 reserved.
REQ-006 The block SHALL have port key_in, input, 256 bits: cipher key, left-aligned; word w[0] = key_in[255:224]; unused low bits are ignored.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the start-accept edge until the final round key is accepted.
REQ-008 The block SHALL have port rk_valid, output, 1 bit: rk_out holds a valid round key.
REQ-009 The block SHALL have port rk_ready, input, 1 bit: the sink accepts the round key; a transfer occurs on an edge with rk_valid=1 and rk_ready=1.
REQ-010 The block SHALL have port rk_out, output, 128 bits: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-011 The block SHALL have port rk_index, output, 4 bits: round number r of rk_out.
REQ-012 The block SHALL have port rk_last, output, 1 bit: rk_valid AND r = Nr.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-014 FSM states SHALL be: IDLE, GEN (producing words), DRAIN (all words produced, final key pending).
- IDLE -> GEN on start with a legal size.
- GEN -> DRAIN when the last word is produced.
- DRAIN -> IDLE on the final transfer.
REQ-015 A start SHALL be legal only if key_size != 11 and Nk <= MAX_NK.
- Illegal start: err=1 on the next cycle; remain IDLE; no other output changes.
REQ-016 Start-accept edge: capture key_size and key_in, clear word counter i = 0, set Rcon = 0x01, set busy = 1.
- start while busy SHALL be ignored.
REQ-017 In GEN, exactly one word w[i] SHALL be produced per unstalled cycle, in order i = 0 .. 4*(Nr+1)-1.
REQ-018 For i < Nk, w[i] SHALL be the corresponding captured key word.
REQ-019 For i >= Nk, w[i] SHALL be w[i-Nk] XOR t, where t = w[i-1], except:
- if i mod Nk = 0: t = SubWord(RotWord(w[i-1])) XOR {Rcon, 24'h0}, after which Rcon <= xtime(Rcon);
- if Nk = 8 and i mod 8 = 4: t = SubWord(w[i-1]).
REQ-020 SubWord SHALL be combinational inside the block, giving zero added latency.
REQ-021 Storage SHALL be a history of the last Nk words (MAX_NK x 32 bits) plus a 3-word assembly buffer.
REQ-022 When word 4r+3 is produced, rk_out/rk_index SHALL load on that same edge and rk_valid SHALL be set.
- This is allowed only if rk_valid=0 or a transfer occurs that edge.
- Otherwise the generator stalls: no word is produced, and i, history and Rcon hold.
REQ-023 rk_out, rk_index and rk_last SHALL be stable while rk_valid=1 and rk_ready=0.
REQ-024 A transfer with no new load that edge SHALL clear rk_valid.
REQ-025 Latency: first rk_valid SHALL rise 4 cycles after the start-accept edge.
- With rk_ready held high, round keys SHALL appear every 4 cycles.
- The final transfer SHALL occur on edge 4*(Nr+1) = 44, 52 or 60 after start.
REQ-026 busy SHALL fall on the cycle after the final transfer; start may be accepted that same cycle.

Reset
REQ-027 While rst=1 at an edge, the block SHALL reset to: state = IDLE, busy=0, rk_valid=0, rk_last=0, err=0, rk_out=0, rk_index=0, i=0, Rcon=0x01.
REQ-028 Reset mid-expansion SHALL discard all partial state; outputs take reset values on the next cycle.
REQ-029 start asserted together with rst SHALL be ignored.

Verification
REQ-030 The bench SHALL apply key_size=00, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1.
- Required: rk index 0 = key; index 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last=1; 11 transfers; final transfer on edge 44.
REQ-031 The bench SHALL apply key_size=01, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
- Required: index 12 = e98ba06f 448c773c 8ecc7204 01002202; 13 transfers.
REQ-032 The bench SHALL apply key_size=10, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
- Required: index 14 = fe4890d1 e6188d0b 046df344 706c631e; 15 transfers.
REQ-033 The bench SHALL drive random rk_ready with 0-7 cycle stalls on the 256-bit vector.
- Required: identical key sequence; rk_out stable during stalls; no key lost or duplicated.
REQ-034 The bench SHALL test rejection and busy-start.
- key_size=11 -> err pulse, busy stays 0.
- With MAX_NK=4, key_size=10 -> err pulse.
- start asserted during busy -> ignored.
REQ-035 The bench SHALL assert rst at round 5 of a 128-bit run.
- Required: next cycle busy=0, rk_valid=0.
- A fresh start then reproduces REQ-030 exactly.
